// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// dmem_arbiter_pkg : shared data-memory request/owner types for the pipeline
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

  localparam int c_ADDR_W   = 32;
  localparam int c_DATA_W   = 32;
  localparam int c_STREAK_W = 4;

  // Who owns the read data returning from memory in the current cycle.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    CORE = 2'd1,
    DMA  = 2'd2
  } mem_owner_e;

  typedef struct packed {
    logic                we;
    logic [c_ADDR_W-1:0] addr;
    logic [c_DATA_W-1:0] wdata;
    logic [2:0]          funct3;
  } mem_req_t;

  localparam mem_req_t c_REQ_IDLE = '0;

endpackage

`default_nettype wire

// File: rtl/dmem_starve_ctr.sv
// ============================================================================
// dmem_starve_ctr : saturating count of core grants while DMA waits
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_starve_ctr
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic core_grant,
  input  logic dma_grant,
  input  logic dma_req,
  output logic dma_prio
);

  localparam logic [c_STREAK_W-1:0] c_MAX = c_STREAK_W'(MAX_STREAK);
  localparam logic [c_STREAK_W-1:0] c_ONE = c_STREAK_W'(1);

  logic [c_STREAK_W-1:0] r_streak;
  logic [c_STREAK_W-1:0] w_streak_nxt;

  always_comb begin
    w_streak_nxt = r_streak;
    if (dma_grant || !dma_req) begin
      w_streak_nxt = '0;
    end else if (core_grant && (r_streak != c_MAX)) begin
      w_streak_nxt = r_streak + c_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else begin
      r_streak <= w_streak_nxt;
    end
  end

  assign dma_prio = (r_streak == c_MAX);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : core/DMA sharing of the data-memory port, core stall, routing
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  input  logic [2:0]        core_funct3_i,
  output logic              core_stall_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  input  logic              dma_req_i,
  output logic              dma_ready_o,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  input  logic [2:0]        dma_funct3_i,
  output logic              dma_rvalid_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  mem_owner_e r_owner;
  mem_owner_e w_owner_nxt;
  mem_req_t   w_core_req;
  mem_req_t   w_dma_req;
  mem_req_t   w_mem_req;
  logic       w_core_pend;
  logic       w_core_grant;
  logic       w_dma_grant;
  logic       w_dma_prio;

  // A held core load must not re-issue while its own data is returning.
  assign w_core_pend  = core_req_i && (r_owner != CORE);
  assign w_dma_grant  = dma_req_i && (w_dma_prio || !w_core_pend);
  assign w_core_grant = w_core_pend && !w_dma_grant;

  dmem_starve_ctr #(
    .MAX_STREAK (MAX_STREAK)
  ) u_starve_ctr (
    .clk        (clk),
    .rst        (rst),
    .core_grant (w_core_grant),
    .dma_grant  (w_dma_grant),
    .dma_req    (dma_req_i),
    .dma_prio   (w_dma_prio)
  );

  always_comb begin
    w_core_req = '{we:     core_we_i,
                   addr:   c_ADDR_W'(core_addr_i),
                   wdata:  c_DATA_W'(core_wdata_i),
                   funct3: core_funct3_i};
    w_dma_req  = '{we:     dma_we_i,
                   addr:   c_ADDR_W'(dma_addr_i),
                   wdata:  c_DATA_W'(dma_wdata_i),
                   funct3: dma_funct3_i};
    w_mem_req  = c_REQ_IDLE;
    if (w_dma_grant) begin
      w_mem_req = w_dma_req;
    end else if (w_core_grant) begin
      w_mem_req = w_core_req;
    end
  end

  assign mem_en_o     = w_dma_grant || w_core_grant;
  assign mem_we_o     = w_mem_req.we;
  assign mem_addr_o   = ADDR_W'(w_mem_req.addr);
  assign mem_wdata_o  = DATA_W'(w_mem_req.wdata);
  assign mem_funct3_o = w_mem_req.funct3;

  assign dma_ready_o  = w_dma_grant;
  assign core_stall_o = w_core_pend && (!w_core_grant || !core_we_i);

  always_comb begin
    w_owner_nxt = NONE;
    if (w_dma_grant && !dma_we_i) begin
      w_owner_nxt = DMA;
    end else if (w_core_grant && !core_we_i) begin
      w_owner_nxt = CORE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  assign core_rvalid_o = (r_owner == CORE);
  assign dma_rvalid_o  = (r_owner == DMA);
  assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
  assign dma_rdata_o   = dma_rvalid_o  ? mem_rdata_i : '0;

endmodule

`default_nettype wire
